// File: rtl/hazard_control_unit_pkg.sv
// rtl/hazard_control_unit_pkg.sv - shared encodings for the pipeline hazard controller
// Purpose: FSM state type, pc_sel encodings and the register-zero constant.
package hazard_control_unit_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_LU_STALL = 1'b1
    } state_t;

    localparam logic [1:0] PCSEL_PC4      = 2'd0;
    localparam logic [1:0] PCSEL_JUMP     = 2'd1;
    localparam logic [1:0] PCSEL_REDIRECT = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// rtl/hazard_control_unit_sat_counter.sv - saturating event counter
// Purpose: counts inc pulses, holds at all-ones, synchronous clear.
// Ports: clk, clear (sync, active-high), inc (count enable), count (current value).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - load-use stall and control-flow flush sequencer
// Purpose: drives PC enable, IF/ID and ID/EX enable/nopper and pc_sel from the
//          hazard inputs in the same cycle; counts stalled cycles and flushes.
// Ports: clk, reset (sync, active-high); id_* decode-stage operand info and jump;
//        ex_* load/redirect info from EX; pc_enable, if_id_enable, if_id_nopper,
//        id_ex_nopper, pc_sel, stall_active control outputs; stall_count and
//        flush_count saturating performance counters.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_redirect,
    output logic             pc_enable,
    output logic             if_id_enable,
    output logic             if_id_nopper,
    output logic             id_ex_nopper,
    output logic [1:0]       pc_sel,
    output logic             stall_active,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    // Bubbles still owed after the first stall cycle.
    localparam logic [1:0] LP_REM_INIT = 2'(STALL_CYCLES - 1);

    state_t     r_state;
    logic [1:0] r_remaining;

    state_t     w_next_state;
    logic [1:0] w_next_remaining;
    logic       w_lu_hit;
    logic       w_stall_inc;
    logic       w_flush_inc;

    assign w_lu_hit = ex_mem_read && (ex_rt != REG_ZERO) &&
                      ((id_uses_rs && (id_rs == ex_rt)) ||
                       (id_uses_rt && (id_rt == ex_rt)));

    always_comb begin
        pc_enable        = 1'b1;
        if_id_enable     = 1'b1;
        if_id_nopper     = 1'b0;
        id_ex_nopper     = 1'b0;
        pc_sel           = PCSEL_PC4;
        stall_active     = 1'b0;
        w_stall_inc      = 1'b0;
        w_flush_inc      = 1'b0;
        w_next_state     = r_state;
        w_next_remaining = r_remaining;

        // A redirect always wins: it squashes both IF and ID, which also
        // discards any stalled instruction, so a pending stall is abandoned.
        if (ex_redirect) begin
            pc_sel           = PCSEL_REDIRECT;
            if_id_nopper     = 1'b1;
            id_ex_nopper     = 1'b1;
            w_flush_inc      = 1'b1;
            w_next_state     = ST_RUN;
            w_next_remaining = 2'd0;
        end else if (r_state == ST_LU_STALL) begin
            // Hazard is not re-evaluated here; the load has already left EX.
            pc_enable        = 1'b0;
            if_id_enable     = 1'b0;
            id_ex_nopper     = 1'b1;
            stall_active     = 1'b1;
            w_stall_inc      = 1'b1;
            w_next_remaining = r_remaining - 2'd1;
            if (r_remaining == 2'd1) begin
                w_next_state = ST_RUN;
            end
        end else if (w_lu_hit) begin
            // Stall beats a jump in ID: the jump is held and redirected later.
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_ex_nopper = 1'b1;
            stall_active = 1'b1;
            w_stall_inc  = 1'b1;
            if (STALL_CYCLES > 1) begin
                w_next_state     = ST_LU_STALL;
                w_next_remaining = LP_REM_INIT;
            end
        end else if (id_jump) begin
            pc_sel       = PCSEL_JUMP;
            if_id_nopper = 1'b1;
            w_flush_inc  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_remaining <= 2'd0;
        end else begin
            r_state     <= w_next_state;
            r_remaining <= w_next_remaining;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (w_stall_inc),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (w_flush_inc),
        .count (flush_count)
    );

endmodule
